// File: rtl/video_pkg.sv
// Shared video-path definitions: intensity mode encodings and default BT.601 weights.
// Latency: not applicable (type and constant definitions only).
// Backpressure: not applicable.
package video_pkg;

    // Intensity selection, captured per pixel at the first pipeline stage.
    typedef enum logic [1:0] {
        MODE_LUMA  = 2'd0,  // weighted BT.601 luma, rounded to nearest
        MODE_MAX   = 2'd1,  // max(r, g, b)
        MODE_FAST  = 2'd2,  // (r + 2g + b) >> 2
        MODE_GREEN = 2'd3   // green passthrough
    } mode_e;

    // Default BT.601 weights as fixed-point fractions of 2**DEF_COEF_W.
    localparam int DEF_COEF_W = 10;
    localparam int DEF_COEF_R = 306;
    localparam int DEF_COEF_G = 601;
    localparam int DEF_COEF_B = 117;

endpackage

// File: rtl/pix_coord_cnt.sv
// Pixel coordinate tracker: x/y counters with frame-start resync and sof/eol/eof flags.
// Latency: combinational; coordinates and flags describe the pixel on the inputs this cycle.
// Backpressure: none; counters advance on every de and hold otherwise.
//
// Ports: clk/rst_n (async active-low), vs frame-start, de pixel valid,
//        cur_x/cur_y coordinates of the incoming pixel, sof/eol/eof position flags
//        (not gated by de; the consumer qualifies them).
module pix_coord_cnt
    import video_pkg::*;
#(
    parameter int H_ACT = 1280,
    parameter int V_ACT = 800,
    localparam int X_W = $clog2(H_ACT),
    localparam int Y_W = $clog2(V_ACT)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           vs,
    input  logic           de,
    output logic [X_W-1:0] cur_x,
    output logic [Y_W-1:0] cur_y,
    output logic           sof,
    output logic           eol,
    output logic           eof
);

    localparam logic [X_W-1:0] X_LAST = X_W'(H_ACT - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACT - 1);

    // Coordinate the next pixel will get unless vs overrides it.
    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;
    logic           x_last;
    logic           y_last;

    // vs arriving together with de makes that very pixel (0,0).
    always_comb begin
        cur_x  = vs ? '0 : x_q;
        cur_y  = vs ? '0 : y_q;
        x_last = (cur_x == X_LAST);
        y_last = (cur_y == Y_LAST);
        sof    = (cur_x == '0) && (cur_y == '0);
        eol    = x_last;
        eof    = x_last && y_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else if (de) begin
            if (x_last) begin
                x_q <= '0;
                y_q <= y_last ? '0 : cur_y + Y_W'(1);
            end else begin
                x_q <= cur_x + X_W'(1);
                y_q <= cur_y;
            end
        end else if (vs) begin
            x_q <= '0;
            y_q <= '0;
        end
    end

endmodule

// File: rtl/rgb_luma_pipe.sv
// RGB-to-intensity converter (luma / max / fast luma / green) with aligned pixel coordinates.
// Latency: fixed 3 cycles from data_de to o_de, one pixel per cycle.
// Backpressure: none; the source must accept one output per input pixel.
//
// Ports: i_pix_clk, rst_n (async active-low); data_vs/data_de/data_r/g/b/mode in;
//        o_de, gray, pix_x, pix_y, o_sof, o_eol, o_eof out.
// Optional macro LUMA_STATS_EN adds per-frame stat_max/stat_sum/stat_vld outputs.
module rgb_luma_pipe
    import video_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int H_ACT  = 1280,
    parameter int V_ACT  = 800,
    parameter int COEF_W = DEF_COEF_W,
    parameter int COEF_R = DEF_COEF_R,
    parameter int COEF_G = DEF_COEF_G,
    parameter int COEF_B = DEF_COEF_B,
    localparam int X_W   = $clog2(H_ACT),
    localparam int Y_W   = $clog2(V_ACT),
    localparam int ACC_W = DATA_W + COEF_W + 2
) (
    input  logic              i_pix_clk,
    input  logic              rst_n,
    input  logic              data_vs,
    input  logic              data_de,
    input  logic [DATA_W-1:0] data_r,
    input  logic [DATA_W-1:0] data_g,
    input  logic [DATA_W-1:0] data_b,
    input  logic [1:0]        mode,
    output logic              o_de,
    output logic [DATA_W-1:0] gray,
    output logic [X_W-1:0]    pix_x,
    output logic [Y_W-1:0]    pix_y,
    output logic              o_sof,
    output logic              o_eol,
    output logic              o_eof
`ifdef LUMA_STATS_EN
    ,
    output logic [DATA_W-1:0]         stat_max,
    output logic [DATA_W+X_W+Y_W-1:0] stat_sum,
    output logic                      stat_vld
`endif
);

    localparam int PROD_W = DATA_W + COEF_W;

    if (COEF_R + COEF_G + COEF_B != (1 << COEF_W)) begin : g_coef_chk
        $error("rgb_luma_pipe: COEF_R+COEF_G+COEF_B must equal 2**COEF_W");
    end

    // ---------------- coordinates of the incoming pixel ----------------
    logic [X_W-1:0] in_x;
    logic [Y_W-1:0] in_y;
    logic           in_sof, in_eol, in_eof;

    pix_coord_cnt #(
        .H_ACT (H_ACT),
        .V_ACT (V_ACT)
    ) u_coord (
        .clk   (i_pix_clk),
        .rst_n (rst_n),
        .vs    (data_vs),
        .de    (data_de),
        .cur_x (in_x),
        .cur_y (in_y),
        .sof   (in_sof),
        .eol   (in_eol),
        .eof   (in_eof)
    );

    // ---------------- S1: products and non-luma candidates ----------------
    logic [DATA_W-1:0] mx_rg, mx_rgb;
    logic [DATA_W+1:0] fast_sum;

    always_comb begin
        mx_rg    = (data_r > data_g) ? data_r : data_g;
        mx_rgb   = (mx_rg > data_b) ? mx_rg : data_b;
        fast_sum = (DATA_W+2)'(data_r) + (DATA_W+2)'({data_g, 1'b0}) + (DATA_W+2)'(data_b);
    end

    logic              v1, sof1, eol1, eof1;
    logic [PROD_W-1:0] pr1, pg1, pb1;
    logic [DATA_W-1:0] max1, fast1, grn1;
    mode_e             mode1;
    logic [X_W-1:0]    x1;
    logic [Y_W-1:0]    y1;

    always_ff @(posedge i_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            pr1   <= '0;
            pg1   <= '0;
            pb1   <= '0;
            max1  <= '0;
            fast1 <= '0;
            grn1  <= '0;
            mode1 <= MODE_LUMA;
            x1    <= '0;
            y1    <= '0;
            sof1  <= 1'b0;
            eol1  <= 1'b0;
            eof1  <= 1'b0;
        end else begin
            v1 <= data_de;
            if (data_de) begin
                pr1   <= PROD_W'(data_r) * PROD_W'(COEF_R);
                pg1   <= PROD_W'(data_g) * PROD_W'(COEF_G);
                pb1   <= PROD_W'(data_b) * PROD_W'(COEF_B);
                max1  <= mx_rgb;
                fast1 <= fast_sum[DATA_W+1:2];
                grn1  <= data_g;
                mode1 <= mode_e'(mode);
                x1    <= in_x;
                y1    <= in_y;
                sof1  <= in_sof;
                eol1  <= in_eol;
                eof1  <= in_eof;
            end
        end
    end

    // ---------------- S2: weighted sum with half-LSB rounding ----------------
    logic              v2, sof2, eol2, eof2;
    logic [ACC_W-1:0]  sum2;
    logic [DATA_W-1:0] max2, fast2, grn2;
    mode_e             mode2;
    logic [X_W-1:0]    x2;
    logic [Y_W-1:0]    y2;

    always_ff @(posedge i_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            sum2  <= '0;
            max2  <= '0;
            fast2 <= '0;
            grn2  <= '0;
            mode2 <= MODE_LUMA;
            x2    <= '0;
            y2    <= '0;
            sof2  <= 1'b0;
            eol2  <= 1'b0;
            eof2  <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                sum2  <= ACC_W'(pr1) + ACC_W'(pg1) + ACC_W'(pb1) + ACC_W'(1 << (COEF_W - 1));
                max2  <= max1;
                fast2 <= fast1;
                grn2  <= grn1;
                mode2 <= mode1;
                x2    <= x1;
                y2    <= y1;
                sof2  <= sof1;
                eol2  <= eol1;
                eof2  <= eof1;
            end
        end
    end

    // ---------------- S3: scale, saturate, select ----------------
    logic [ACC_W-1:0]  shifted;
    logic [DATA_W-1:0] luma, result;

    always_comb begin
        shifted = sum2 >> COEF_W;
        // Only reachable with coefficient sets whose rounding pushes past full scale.
        luma    = (shifted > ACC_W'((1 << DATA_W) - 1)) ? '1 : shifted[DATA_W-1:0];
        case (mode2)
            MODE_LUMA: result = luma;
            MODE_MAX:  result = max2;
            MODE_FAST: result = fast2;
            default:   result = grn2;
        endcase
    end

    // Data outputs hold through bubbles; flags are only ever high with o_de.
    always_ff @(posedge i_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            o_de  <= 1'b0;
            gray  <= '0;
            pix_x <= '0;
            pix_y <= '0;
            o_sof <= 1'b0;
            o_eol <= 1'b0;
            o_eof <= 1'b0;
        end else begin
            o_de  <= v2;
            o_sof <= v2 & sof2;
            o_eol <= v2 & eol2;
            o_eof <= v2 & eof2;
            if (v2) begin
                gray  <= result;
                pix_x <= x2;
                pix_y <= y2;
            end
        end
    end

`ifdef LUMA_STATS_EN
    // ---------------- per-frame statistics on the output stream ----------------
    localparam int SUM_W = DATA_W + X_W + Y_W;

    logic [SUM_W-1:0]  acc_sum, sum_tot;
    logic [DATA_W-1:0] acc_max, max_tot;

    // sof restarts the frame, so a frame cut short by vs never reaches eof.
    always_comb begin
        sum_tot = (o_sof ? '0 : acc_sum) + SUM_W'(gray);
        max_tot = (o_sof || (gray > acc_max)) ? gray : acc_max;
    end

    always_ff @(posedge i_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_sum  <= '0;
            acc_max  <= '0;
            stat_sum <= '0;
            stat_max <= '0;
            stat_vld <= 1'b0;
        end else begin
            stat_vld <= o_de & o_eof;
            if (o_de) begin
                acc_sum <= sum_tot;
                acc_max <= max_tot;
                if (o_eof) begin
                    stat_sum <= sum_tot;
                    stat_max <= max_tot;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_rgb_luma_pipe.sv
// Self-checking bench for rgb_luma_pipe: scoreboard of expected pixels checked at the output.
// Latency: every output is required exactly 3 cycles after its input pixel.
// Backpressure: none exercised; the design has none.
module tb_rgb_luma_pipe;
    import video_pkg::*;

    localparam int H_ACT = 1280;
    localparam int V_ACT = 4;
    localparam int X_W   = $clog2(H_ACT);
    localparam int Y_W   = $clog2(V_ACT);

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       vs    = 1'b0;
    logic       de    = 1'b0;
    logic [7:0] r = '0, g = '0, b = '0;
    logic [1:0] mode = '0;

    logic           o_de, o_sof, o_eol, o_eof;
    logic [7:0]     gray;
    logic [X_W-1:0] pix_x;
    logic [Y_W-1:0] pix_y;

`ifdef LUMA_STATS_EN
    logic [7:0]             stat_max;
    logic [8+X_W+Y_W-1:0]   stat_sum;
    logic                   stat_vld;
    logic       s_vs = 1'b0, s_de = 1'b0;
    logic       s_o_de, s_o_sof, s_o_eol, s_o_eof, s_stat_vld;
    logic [7:0] s_gray, s_stat_max;
    logic [1:0] s_pix_x;
    logic       s_pix_y;
    logic [10:0] s_stat_sum;
`endif

    always #5 clk = ~clk;

    rgb_luma_pipe #(.H_ACT(H_ACT), .V_ACT(V_ACT)) dut (
        .i_pix_clk (clk),   .rst_n   (rst_n),
        .data_vs   (vs),    .data_de (de),
        .data_r    (r),     .data_g  (g),     .data_b (b),
        .mode      (mode),
        .o_de      (o_de),  .gray    (gray),
        .pix_x     (pix_x), .pix_y   (pix_y),
        .o_sof     (o_sof), .o_eol   (o_eol), .o_eof  (o_eof)
`ifdef LUMA_STATS_EN
        ,
        .stat_max  (stat_max), .stat_sum (stat_sum), .stat_vld (stat_vld)
`endif
    );

`ifdef LUMA_STATS_EN
    rgb_luma_pipe #(.H_ACT(4), .V_ACT(2)) dut_small (
        .i_pix_clk (clk),     .rst_n   (rst_n),
        .data_vs   (s_vs),    .data_de (s_de),
        .data_r    (r),       .data_g  (g),       .data_b (b),
        .mode      (mode),
        .o_de      (s_o_de),  .gray    (s_gray),
        .pix_x     (s_pix_x), .pix_y   (s_pix_y),
        .o_sof     (s_o_sof), .o_eol   (s_o_eol), .o_eof  (s_o_eof),
        .stat_max  (s_stat_max), .stat_sum (s_stat_sum), .stat_vld (s_stat_vld)
    );
`endif

    typedef struct {
        logic [7:0]     gray;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic           sof, eol, eof;
        int             issue;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int bx = 0, by = 0;
    int cnt_sof = 0, cnt_eol = 0, cnt_eof = 0;
    logic mon_en = 1'b0;
    logic [7:0]     last_gray = '0;
    logic [X_W-1:0] last_x = '0;
    logic [Y_W-1:0] last_y = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference intensity for the default BT.601 weights.
    function automatic int model(input int rr, input int gg, input int bb, input int m);
        int mx;
        case (m)
            0: return (rr * 306 + gg * 601 + bb * 117 + 512) >> 10;
            1: begin
                mx = rr;
                if (gg > mx) mx = gg;
                if (bb > mx) mx = bb;
                return mx;
            end
            2: return (rr + 2 * gg + bb) >> 2;
            default: return gg;
        endcase
    endfunction

    // Output monitor: pops the scoreboard on each o_de, checks bubble behaviour otherwise.
    always @(negedge clk) begin
        if (mon_en) begin
            n_chk++;
            if (o_de) begin
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: o_de=1 gray=%0d x=%0d y=%0d, want no output", gray, pix_x, pix_y);
                end else begin
                    mon_e = sb.pop_front();
                    if (gray !== mon_e.gray || pix_x !== mon_e.x || pix_y !== mon_e.y ||
                        {o_sof, o_eol, o_eof} !== {mon_e.sof, mon_e.eol, mon_e.eof} ||
                        cyc - mon_e.issue != 3) begin
                        n_fail++;
                        $display("FAIL pixel_out: got gray=%0d x=%0d y=%0d flags=%b%b%b lat=%0d, want gray=%0d x=%0d y=%0d flags=%b%b%b lat=3",
                                 gray, pix_x, pix_y, o_sof, o_eol, o_eof, cyc - mon_e.issue,
                                 mon_e.gray, mon_e.x, mon_e.y, mon_e.sof, mon_e.eol, mon_e.eof);
                    end
                    last_gray = mon_e.gray;
                    last_x    = mon_e.x;
                    last_y    = mon_e.y;
                    if (o_sof) cnt_sof++;
                    if (o_eol) cnt_eol++;
                    if (o_eof) cnt_eof++;
                end
            end else if ({o_sof, o_eol, o_eof} !== 3'b000 || gray !== last_gray ||
                         pix_x !== last_x || pix_y !== last_y) begin
                n_fail++;
                $display("FAIL bubble_hold: got gray=%0d x=%0d y=%0d flags=%b%b%b, want gray=%0d x=%0d y=%0d flags=000",
                         gray, pix_x, pix_y, o_sof, o_eol, o_eof, last_gray, last_x, last_y);
            end
        end
    end

    // Drive one pixel for one cycle and record what must come out of the pipe.
    task automatic pix(input int rr, input int gg, input int bb, input int mm, input logic vv, input int eg);
        exp_t e;
        if (vv) begin
            bx = 0;
            by = 0;
        end
        e.gray  = eg[7:0];
        e.x     = X_W'(bx);
        e.y     = Y_W'(by);
        e.sof   = (bx == 0) && (by == 0);
        e.eol   = (bx == H_ACT - 1);
        e.eof   = e.eol && (by == V_ACT - 1);
        e.issue = cyc;
        sb.push_back(e);
        r = 8'(rr); g = 8'(gg); b = 8'(bb); mode = 2'(mm); vs = vv; de = 1'b1;
        bx++;
        if (bx == H_ACT) begin
            bx = 0;
            by = (by + 1) % V_ACT;
        end
        @(posedge clk); #1;
        de = 1'b0;
        vs = 1'b0;
    endtask

    task automatic rpix(input int mm);
        int rr, gg, bb;
        rr = $urandom_range(0, 255);
        gg = $urandom_range(0, 255);
        bb = $urandom_range(0, 255);
        pix(rr, gg, bb, mm, 1'b0, model(rr, gg, bb, mm));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic vs_only();
        vs = 1'b1;
        bx = 0;
        by = 0;
        @(posedge clk); #1;
        vs = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk); #1;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d pixels still pending, want 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_chk++;
        if (o_de !== 1'b0) begin n_fail++; $display("FAIL reset_o_de: got %b want 0", o_de); end
        n_chk++;
        if (gray !== 8'd0) begin n_fail++; $display("FAIL reset_gray: got %0d want 0", gray); end
        n_chk++;
        if (pix_x !== '0 || pix_y !== '0) begin
            n_fail++; $display("FAIL reset_xy: got (%0d,%0d) want (0,0)", pix_x, pix_y);
        end
        n_chk++;
        if ({o_sof, o_eol, o_eof} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b%b%b want 000", o_sof, o_eol, o_eof);
        end
`ifdef LUMA_STATS_EN
        n_chk++;
        if (stat_vld !== 1'b0 || stat_max !== '0 || stat_sum !== '0) begin
            n_fail++; $display("FAIL reset_stats: got vld=%b max=%0d sum=%0d want 0", stat_vld, stat_max, stat_sum);
        end
`endif
        rst_n  = 1'b1;
        mon_en = 1'b1;
        idle(2);
    endtask

    task automatic test_luma();
        pix(255, 255, 255, 0, 1'b0, 255);
        idle(2);
        // (30600 + 30050 + 23400 + 512) >> 10 = 84562 >> 10 = 82
        pix(100, 50, 200, 0, 1'b0, 82);
        pix(0, 0, 0, 0, 1'b0, 0);
        idle(1);
        pix(255, 0, 0, 0, 1'b0, 76);
        drain("luma");
    endtask

    task automatic test_modes();
        pix(10, 200, 30, 1, 1'b0, 200);
        pix(10, 200, 30, 2, 1'b0, 110);
        pix(10, 200, 30, 3, 1'b0, 200);
        for (int i = 0; i < 40; i++) rpix(i % 4);
        drain("modes");
    endtask

    task automatic test_frame_walk();
        vs_only();
        cnt_sof = 0; cnt_eol = 0; cnt_eof = 0;
        for (int i = 0; i < H_ACT * V_ACT; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            rpix($urandom_range(0, 3));
        end
        drain("frame");
        n_chk++;
        if (cnt_sof != 1) begin n_fail++; $display("FAIL frame_sof_count: got %0d want 1", cnt_sof); end
        n_chk++;
        if (cnt_eol != V_ACT) begin n_fail++; $display("FAIL frame_eol_count: got %0d want %0d", cnt_eol, V_ACT); end
        n_chk++;
        if (cnt_eof != 1) begin n_fail++; $display("FAIL frame_eof_count: got %0d want 1", cnt_eof); end
        // The pixel after the frame wraps to (0,0) without any vs.
        rpix(0);
        drain("frame_wrap");
        n_chk++;
        if (cnt_sof != 2) begin n_fail++; $display("FAIL frame_wrap_sof: got %0d want 2", cnt_sof); end
    endtask

    task automatic test_resync();
        vs_only();
        cnt_sof = 0; cnt_eol = 0; cnt_eof = 0;
        for (int i = 0; i < H_ACT * 3 + 500; i++) rpix($urandom_range(0, 3));
        pix(1, 2, 3, 3, 1'b1, 2);
        rpix(1);
        rpix(2);
        drain("resync");
        n_chk++;
        if (cnt_sof != 2 || cnt_eol != 3 || cnt_eof != 0) begin
            n_fail++;
            $display("FAIL resync_flags: got sof=%0d eol=%0d eof=%0d want sof=2 eol=3 eof=0", cnt_sof, cnt_eol, cnt_eof);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 30; i++) rpix($urandom_range(0, 3));
        // The last pixels are still inside the pipe when reset hits.
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        n_chk++;
        if ({o_de, gray, pix_x, pix_y, o_sof, o_eol, o_eof} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got de=%b gray=%0d x=%0d y=%0d want all 0", o_de, gray, pix_x, pix_y);
        end
        sb.delete();
        bx = 0; by = 0;
        last_gray = '0; last_x = '0; last_y = '0;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        idle(4);
        for (int i = 0; i < 5; i++) rpix(i % 4);
        drain("midreset");
    endtask

`ifdef LUMA_STATS_EN
    task automatic test_stats();
        int eof_cyc, vld_cyc, vld_cnt;
        logic [7:0]  smax;
        logic [10:0] ssum;
        eof_cyc = -10; vld_cyc = -1; vld_cnt = 0; smax = '0; ssum = '0;
        s_vs = 1'b1;
        @(posedge clk); #1;
        s_vs = 1'b0;
        for (int i = 0; i < 8; i++) begin
            r = 8'd0; b = 8'd0; g = 8'(i); mode = 2'd3; s_de = 1'b1;
            @(posedge clk); #1;
        end
        s_de = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (s_o_de && s_o_eof) eof_cyc = cyc;
            if (s_stat_vld) begin
                vld_cnt++; vld_cyc = cyc; smax = s_stat_max; ssum = s_stat_sum;
            end
        end
        @(posedge clk); #1;
        n_chk++;
        if (vld_cnt != 1) begin n_fail++; $display("FAIL stats_vld_count: got %0d want 1", vld_cnt); end
        n_chk++;
        if (vld_cyc != eof_cyc + 1) begin n_fail++; $display("FAIL stats_vld_timing: got cycle %0d want %0d", vld_cyc, eof_cyc + 1); end
        n_chk++;
        if (smax !== 8'd7) begin n_fail++; $display("FAIL stats_max: got %0d want 7", smax); end
        n_chk++;
        if (ssum !== 11'd28) begin n_fail++; $display("FAIL stats_sum: got %0d want 28", ssum); end
    endtask
`endif

    initial begin
        test_reset();
        test_luma();
        test_modes();
        test_frame_walk();
        test_resync();
        test_mid_reset();
`ifdef LUMA_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d pixels pending", sb.size());
        $fatal(1, "watchdog");
    end

endmodule
